// File: rtl/mem_writeback_unit_if.sv
// Data-memory bus between the MW stage (master) and the data memory (slave).
// Carries the request handshake, store payload and load response.
interface mem_writeback_unit_if;
  logic        memReqValid;
  logic        memReqReady;
  logic [31:0] memAddr;
  logic        memWrite;
  logic [31:0] memWdata;
  logic [3:0]  memByteEnable;
  logic        memRespValid;
  logic [31:0] memRespData;

  modport master (
    output memReqValid, memAddr, memWrite, memWdata, memByteEnable,
    input  memReqReady, memRespValid, memRespData
  );

  modport slave (
    input  memReqValid, memAddr, memWrite, memWdata, memByteEnable,
    output memReqReady, memRespValid, memRespData
  );
endinterface

// File: rtl/mem_writeback_unit.sv
// Memory/writeback stage of the 3-stage core: accepts executed instructions,
// runs load/store handshakes on the data bus, aligns load data and drives the
// register file write port (registered on posedge, sampled by the file on negedge).
module mem_writeback_unit #(
  parameter int RESP_TIMEOUT = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                validE,
  input  logic                regWriteE,
  input  logic [4:0]          writeAddressE,
  input  logic [31:0]         aluResultE,
  input  logic                memReadE,
  input  logic                memWriteE,
  input  logic [2:0]          funct3E,
  input  logic [31:0]         storeDataE,
  output logic                stallE,
  mem_writeback_unit_if.master mem,
  output logic                writeEnableMW,
  output logic [4:0]          writeAddressMW,
  output logic [31:0]         writeData,
  output logic                accessFaultMW
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t      r_state, w_state_next;
  logic [4:0]  r_rd, w_rd_next;
  logic [2:0]  r_funct3, w_funct3_next;
  logic [1:0]  r_addr_lo, w_addr_lo_next;
  logic [31:0] r_tcnt, w_tcnt_next;
  logic        r_req_valid, w_req_valid_next;
  logic [31:0] r_mem_addr, w_mem_addr_next;
  logic        r_mem_write, w_mem_write_next;
  logic [31:0] r_mem_wdata, w_mem_wdata_next;
  logic [3:0]  r_mem_be, w_mem_be_next;
  logic        r_we, w_we_next;
  logic [4:0]  r_waddr, w_waddr_next;
  logic [31:0] r_wdata, w_wdata_next;
  logic        r_fault, w_fault_next;

  logic        w_mem_fault;
  logic [3:0]  w_st_be;
  logic [31:0] w_st_data;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_ld_value;
  logic [31:0] w_tcnt_inc;
  logic        w_timeout_hit;

  // Decode illegal memory accesses: reserved size codes, misalignment, load+store.
  always_comb begin
    w_mem_fault = (funct3E == 3'b011) || (funct3E[2:1] == 2'b11) ||
                  (memReadE && memWriteE) ||
                  ((funct3E[1:0] == 2'b01) && aluResultE[0]) ||
                  ((funct3E[1:0] == 2'b10) && (aluResultE[1:0] != 2'b00));
  end

  // Store lane steering: byte enables shifted to the target lane, data replicated across lanes.
  always_comb begin
    case (funct3E[1:0])
      2'b00: begin
        w_st_be   = 4'b0001 << aluResultE[1:0];
        w_st_data = {4{storeDataE[7:0]}};
      end
      2'b01: begin
        w_st_be   = 4'b0011 << aluResultE[1:0];
        w_st_data = {2{storeDataE[15:0]}};
      end
      default: begin
        w_st_be   = 4'b1111;
        w_st_data = storeDataE;
      end
    endcase
  end

  // Load alignment: pick the addressed byte/halfword and sign- or zero-extend it.
  always_comb begin
    case (r_addr_lo)
      2'd0:    w_ld_byte = mem.memRespData[7:0];
      2'd1:    w_ld_byte = mem.memRespData[15:8];
      2'd2:    w_ld_byte = mem.memRespData[23:16];
      default: w_ld_byte = mem.memRespData[31:24];
    endcase
    w_ld_half = r_addr_lo[1] ? mem.memRespData[31:16] : mem.memRespData[15:0];
    case (r_funct3)
      3'b000:  w_ld_value = {{24{w_ld_byte[7]}}, w_ld_byte};
      3'b100:  w_ld_value = {24'd0, w_ld_byte};
      3'b001:  w_ld_value = {{16{w_ld_half[15]}}, w_ld_half};
      3'b101:  w_ld_value = {16'd0, w_ld_half};
      default: w_ld_value = mem.memRespData;
    endcase
  end

  assign w_tcnt_inc    = r_tcnt + 32'd1;
  assign w_timeout_hit = (RESP_TIMEOUT != 0) && (w_tcnt_inc == 32'(RESP_TIMEOUT));

  // Next-state and next-output logic; pulse outputs default low every cycle.
  always_comb begin
    w_state_next     = r_state;
    w_rd_next        = r_rd;
    w_funct3_next    = r_funct3;
    w_addr_lo_next   = r_addr_lo;
    w_tcnt_next      = r_tcnt;
    w_req_valid_next = r_req_valid;
    w_mem_addr_next  = r_mem_addr;
    w_mem_write_next = r_mem_write;
    w_mem_wdata_next = r_mem_wdata;
    w_mem_be_next    = r_mem_be;
    w_we_next        = 1'b0;
    w_waddr_next     = r_waddr;
    w_wdata_next     = r_wdata;
    w_fault_next     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (validE) begin
          if (!memReadE && !memWriteE) begin
            w_we_next    = regWriteE && (writeAddressE != 5'd0);
            w_waddr_next = writeAddressE;
            w_wdata_next = aluResultE;
          end else if (w_mem_fault) begin
            w_fault_next = 1'b1;
          end else begin
            w_rd_next        = writeAddressE;
            w_funct3_next    = funct3E;
            w_addr_lo_next   = aluResultE[1:0];
            w_req_valid_next = 1'b1;
            w_mem_addr_next  = {aluResultE[31:2], 2'b00};
            w_mem_write_next = memWriteE;
            w_mem_wdata_next = memWriteE ? w_st_data : 32'd0;
            w_mem_be_next    = memWriteE ? w_st_be : 4'b0000;
            w_state_next     = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem.memReqReady) begin
          w_req_valid_next = 1'b0;
          w_mem_addr_next  = 32'd0;
          w_mem_write_next = 1'b0;
          w_mem_wdata_next = 32'd0;
          w_mem_be_next    = 4'b0000;
          w_tcnt_next      = 32'd0;
          w_state_next     = r_mem_write ? S_IDLE : S_RESP;
        end
      end
      S_RESP: begin
        if (mem.memRespValid) begin
          w_we_next    = (r_rd != 5'd0);
          w_waddr_next = r_rd;
          w_wdata_next = w_ld_value;
          w_tcnt_next  = 32'd0;
          w_state_next = S_IDLE;
        end else if (w_timeout_hit) begin
          w_fault_next = 1'b1;
          w_tcnt_next  = 32'd0;
          w_state_next = S_IDLE;
        end else begin
          w_tcnt_next = w_tcnt_inc;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight access.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rd        <= 5'd0;
      r_funct3    <= 3'd0;
      r_addr_lo   <= 2'd0;
      r_tcnt      <= 32'd0;
      r_req_valid <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_write <= 1'b0;
      r_mem_wdata <= 32'd0;
      r_mem_be    <= 4'b0000;
      r_we        <= 1'b0;
      r_waddr     <= 5'd0;
      r_wdata     <= 32'd0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_rd        <= w_rd_next;
      r_funct3    <= w_funct3_next;
      r_addr_lo   <= w_addr_lo_next;
      r_tcnt      <= w_tcnt_next;
      r_req_valid <= w_req_valid_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_write <= w_mem_write_next;
      r_mem_wdata <= w_mem_wdata_next;
      r_mem_be    <= w_mem_be_next;
      r_we        <= w_we_next;
      r_waddr     <= w_waddr_next;
      r_wdata     <= w_wdata_next;
      r_fault     <= w_fault_next;
    end
  end

  assign stallE            = (r_state != S_IDLE);
  assign mem.memReqValid   = r_req_valid;
  assign mem.memAddr       = r_mem_addr;
  assign mem.memWrite      = r_mem_write;
  assign mem.memWdata      = r_mem_wdata;
  assign mem.memByteEnable = r_mem_be;
  assign writeEnableMW     = r_we;
  assign writeAddressMW    = r_waddr;
  assign writeData         = r_wdata;
  assign accessFaultMW     = r_fault;

endmodule
